// File: rtl/pwm_pkg.sv
// Shared widths and types for the PWM edge preconditioner.
// Edge times are modulo the ultrasound cycle.
package pwm_pkg;

    localparam int PWM_WIDTH = 13;
    localparam int PWM_DEPTH = 249;
    localparam int PWM_IDX_W = $clog2(PWM_DEPTH);

    typedef logic [PWM_IDX_W-1:0] pwm_idx_t;

    typedef struct packed {
        logic [PWM_WIDTH-1:0] rise;
        logic [PWM_WIDTH-1:0] fall;
        logic                 full_width;
    } pwm_edge_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// Stage-2 raw edge arithmetic and stage-3 modulo wrap.
// Purely combinational; the parent owns every register.
module pwm_edge_calc
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic [WIDTH-1:0]        i_cycle,
    input  logic [WIDTH-1:0]        i_duty,
    input  logic [WIDTH-1:0]        i_phase,
    output logic signed [WIDTH:0]   o_r_raw,
    output logic signed [WIDTH:0]   o_f_raw,
    output logic                    o_full,
    input  logic signed [WIDTH:0]   i_r_raw,
    input  logic signed [WIDTH:0]   i_f_raw,
    input  logic                    i_full,
    output logic [WIDTH-1:0]        o_rise,
    output logic [WIDTH-1:0]        o_fall,
    output logic                    o_full_width
);

    logic [WIDTH:0] w_duty_x;
    logic [WIDTH:0] w_phase_x;
    logic [WIDTH:0] w_cycle_x;
    logic [WIDTH:0] w_half_dn;
    logic [WIDTH:0] w_half_up;
    logic           w_r_neg;
    logic           w_f_over;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    assign w_duty_x  = {1'b0, i_duty};
    assign w_phase_x = {1'b0, i_phase};
    assign w_cycle_x = {1'b0, i_cycle};
    assign w_half_dn = w_duty_x >> 1;
    assign w_half_up = (w_duty_x + (WIDTH+1)'(1)) >> 1;

    assign o_r_raw = signed'(w_phase_x - w_half_dn);
    assign o_f_raw = signed'(w_phase_x + w_half_up);
    assign o_full  = (i_duty >= i_cycle);

    // f_raw is never negative, so compare it unsigned for extra headroom
    assign w_r_neg  = i_r_raw[WIDTH];
    assign w_f_over = (unsigned'(i_f_raw) >= w_cycle_x);

    assign w_rise = w_r_neg  ? i_r_raw[WIDTH-1:0] + i_cycle
                             : i_r_raw[WIDTH-1:0];
    assign w_fall = w_f_over ? i_f_raw[WIDTH-1:0] - i_cycle
                             : i_f_raw[WIDTH-1:0];

    assign o_rise       = i_full ? '0 : w_rise;
    assign o_fall       = i_full ? '0 : w_fall;
    assign o_full_width = i_full;

endmodule

// File: rtl/pwm_preconditioner.sv
// Three-stage pipeline turning (duty, phase) pairs into indexed
// PWM rise/fall times modulo CYCLE.
module pwm_preconditioner
    import pwm_pkg::*;
#(
    parameter  int WIDTH = PWM_WIDTH,
    parameter  int DEPTH = PWM_DEPTH,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] CYCLE,
    input  logic             DIN_VALID,
    input  logic             DIN_FIRST,
    input  logic [WIDTH-1:0] DUTY,
    input  logic [WIDTH-1:0] PHASE,
    output logic             DOUT_VALID,
    output logic [IW-1:0]    IDX,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             FULL_WIDTH,
    output logic             FRAME_DONE
);

    logic [IW-1:0]    r_cnt;
    logic             r1_valid;
    logic [WIDTH-1:0] r1_duty;
    logic [WIDTH-1:0] r1_phase;
    logic [IW-1:0]    r1_idx;
    logic             r2_valid;
    logic signed [WIDTH:0] r2_r_raw;
    logic signed [WIDTH:0] r2_f_raw;
    logic             r2_full;
    logic [IW-1:0]    r2_idx;
    logic             r_dout_valid;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_full_width;
    logic             r_frame_done;

    logic [IW-1:0]    w_idx_in;
    logic [WIDTH-1:0] w_phase_n;
    logic signed [WIDTH:0] w_r_raw;
    logic signed [WIDTH:0] w_f_raw;
    logic             w_full;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic             w_full_width;

    assign w_idx_in  = DIN_FIRST ? '0 : r_cnt;
    assign w_phase_n = (PHASE >= CYCLE) ? PHASE - CYCLE : PHASE;

    pwm_edge_calc #(.WIDTH(WIDTH)) u_calc (
        .i_cycle      (CYCLE),
        .i_duty       (r1_duty),
        .i_phase      (r1_phase),
        .o_r_raw      (w_r_raw),
        .o_f_raw      (w_f_raw),
        .o_full       (w_full),
        .i_r_raw      (r2_r_raw),
        .i_f_raw      (r2_f_raw),
        .i_full       (r2_full),
        .o_rise       (w_rise),
        .o_fall       (w_fall),
        .o_full_width (w_full_width)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt        <= '0;
            r1_valid     <= 1'b0;
            r1_duty      <= '0;
            r1_phase     <= '0;
            r1_idx       <= '0;
            r2_valid     <= 1'b0;
            r2_r_raw     <= '0;
            r2_f_raw     <= '0;
            r2_full      <= 1'b0;
            r2_idx       <= '0;
            r_dout_valid <= 1'b0;
            r_idx        <= '0;
            r_rise       <= '0;
            r_fall       <= '0;
            r_full_width <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r1_valid <= DIN_VALID;
            if (DIN_VALID) begin
                r_cnt    <= (w_idx_in == IW'(DEPTH-1)) ? '0
                                                       : w_idx_in + IW'(1);
                r1_duty  <= DUTY;
                r1_phase <= w_phase_n;
                r1_idx   <= w_idx_in;
            end

            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_r_raw <= w_r_raw;
                r2_f_raw <= w_f_raw;
                r2_full  <= w_full;
                r2_idx   <= r1_idx;
            end

            // outputs hold their last value across gaps
            r_dout_valid <= r2_valid;
            r_frame_done <= r2_valid && (r2_idx == IW'(DEPTH-1));
            if (r2_valid) begin
                r_rise       <= w_rise;
                r_fall       <= w_fall;
                r_full_width <= w_full_width;
                r_idx        <= r2_idx;
            end
        end
    end

    assign DOUT_VALID = r_dout_valid;
    assign IDX        = r_idx;
    assign RISE       = r_rise;
    assign FALL       = r_fall;
    assign FULL_WIDTH = r_full_width;
    assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Directed and random bench for pwm_preconditioner, checked against
// an arithmetic reference model with a timed expectation queue.
module tb_pwm_preconditioner;

    localparam int W = 13;
    localparam int D = 249;

    logic         CLK;
    logic         RST_N;
    logic [W-1:0] CYCLE;
    logic         DIN_VALID;
    logic         DIN_FIRST;
    logic [W-1:0] DUTY;
    logic [W-1:0] PHASE;
    logic         DOUT_VALID;
    logic [7:0]   IDX;
    logic [W-1:0] RISE;
    logic [W-1:0] FALL;
    logic         FULL_WIDTH;
    logic         FRAME_DONE;

    pwm_preconditioner dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .CYCLE      (CYCLE),
        .DIN_VALID  (DIN_VALID),
        .DIN_FIRST  (DIN_FIRST),
        .DUTY       (DUTY),
        .PHASE      (PHASE),
        .DOUT_VALID (DOUT_VALID),
        .IDX        (IDX),
        .RISE       (RISE),
        .FALL       (FALL),
        .FULL_WIDTH (FULL_WIDTH),
        .FRAME_DONE (FRAME_DONE)
    );

    typedef struct {
        int idx;
        int rise;
        int fall;
        int full;
        int due;
    } exp_t;

    exp_t q[$];
    int   m_cnt = 0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: every emitted sample must match the queue head
    always @(posedge CLK) begin
        cyc++;
        #1;
        if (RST_N) begin
            if (DOUT_VALID) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency", cyc, e.due);
                    chk("idx", IDX, e.idx);
                    chk("rise", RISE, e.rise);
                    chk("fall", FALL, e.fall);
                    chk("full_width", FULL_WIDTH, e.full);
                    chk("frame_done", FRAME_DONE, (e.idx == D-1) ? 1 : 0);
                    chk("rise_range", (RISE < CYCLE) ? 1 : 0, 1);
                    chk("fall_range", (FALL < CYCLE) ? 1 : 0, 1);
                end
            end else begin
                chk("frame_done_idle", FRAME_DONE, 0);
                while (q.size() != 0 && q[0].due <= cyc) begin
                    void'(q.pop_front());
                    chk("missing_output", 0, 1);
                end
            end
        end
    end

    task automatic send(input bit first, input int duty, input int phase);
        exp_t e;
        int c;
        int p;
        @(negedge CLK);
        DIN_VALID = 1'b1;
        DIN_FIRST = first;
        DUTY      = W'(duty);
        PHASE     = W'(phase);
        c = int'(CYCLE);
        p = (phase >= c) ? phase - c : phase;
        e.idx = first ? 0 : m_cnt;
        m_cnt = (e.idx + 1) % D;
        if (duty >= c) begin
            e.rise = 0;
            e.fall = 0;
            e.full = 1;
        end else begin
            e.rise = (((p - duty / 2) % c) + c) % c;
            e.fall = (p + (duty + 1) / 2) % c;
            e.full = 0;
        end
        e.due = cyc + 3;
        q.push_back(e);
    endtask

    // Idle cycles carry junk data and a stray DIN_FIRST that must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            DIN_VALID = 1'b0;
            DIN_FIRST = 1'($urandom_range(0, 1));
            DUTY      = W'($urandom);
            PHASE     = W'($urandom);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_dout_valid", DOUT_VALID, 0);
        chk("rst_frame_done", FRAME_DONE, 0);
        chk("rst_full_width", FULL_WIDTH, 0);
        chk("rst_rise", RISE, 0);
        chk("rst_fall", FALL, 0);
        chk("rst_idx", IDX, 0);
    endtask

    initial begin
        RST_N     = 1'b0;
        CYCLE     = W'(4096);
        DIN_VALID = 1'b0;
        DIN_FIRST = 1'b0;
        DUTY      = '0;
        PHASE     = '0;
        #1;
        chk_reset_vals();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        idle(2);

        send(0, 2048, 0);
        send(0, 0, 100);
        send(0, 4096, 7);
        send(0, 101, 4095);
        send(0, 1, 0);
        send(0, 4095, 2000);
        send(0, 300, 5000);
        idle(6);

        send(1, 10, 20);
        for (int i = 1; i < D + 2; i++)
            send(0, $urandom_range(0, 4200), $urandom_range(0, 4095));
        idle(6);

        send(1, 50, 60);
        for (int i = 1; i < D + 2; i++) begin
            if ($urandom_range(0, 2) == 0)
                idle($urandom_range(1, 3));
            send(0, $urandom_range(0, 4200), $urandom_range(0, 4095));
        end
        idle(6);

        for (int i = 0; i < 10; i++)
            send(0, $urandom_range(0, 4095), $urandom_range(0, 4095));
        send(1, 777, 333);
        send(0, 888, 444);
        idle(6);

        send(0, 500, 10);
        send(0, 600, 20);
        @(negedge CLK);
        RST_N     = 1'b0;
        DIN_VALID = 1'b0;
        q.delete();
        m_cnt = 0;
        #1;
        chk_reset_vals();
        @(negedge CLK);
        RST_N = 1'b1;
        idle(5);
        send(0, 2048, 0);
        send(0, 1, 0);
        idle(6);

        CYCLE = W'(2000);
        idle(2);
        send(1, 1000, 0);
        for (int i = 1; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0)
                idle(1);
            send(0, $urandom_range(0, 1999), $urandom_range(0, 1999));
        end
        idle(8);

        chk("pending_at_end", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
